// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register of the RV32I core: regfile address
// drive, writeback bypass, immediate generation, load-use bubble insertion.
module id_ex_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RF_ADD_SIZE = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  input  logic [31:0]            i_instr,
  input  logic [WIDTH-1:0]       i_pc,
  output logic [RF_ADD_SIZE-1:0] o_rs1_addr,
  output logic [RF_ADD_SIZE-1:0] o_rs2_addr,
  input  logic [WIDTH-1:0]       i_rs1_data,
  input  logic [WIDTH-1:0]       i_rs2_data,
  input  logic                   i_wb_we,
  input  logic [RF_ADD_SIZE-1:0] i_wb_rd,
  input  logic [WIDTH-1:0]       i_wb_data,
  input  logic                   i_flush,
  input  logic                   i_hold,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_pc,
  output logic [31:0]            o_instr,
  output logic [WIDTH-1:0]       o_rs1_val,
  output logic [WIDTH-1:0]       o_rs2_val,
  output logic [WIDTH-1:0]       o_imm,
  output logic [RF_ADD_SIZE-1:0] o_rd,
  output logic                   o_rd_we,
  output logic                   o_is_load
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  opcode_e                opcode;
  logic [RF_ADD_SIZE-1:0] rs1, rs2, rd;
  logic                   use_rs1, use_rs2, rd_we, is_load, lu;
  logic [31:0]            imm32;

  logic                   valid_q,   valid_d;
  logic [WIDTH-1:0]       pc_q,      pc_d;
  logic [31:0]            instr_q,   instr_d;
  logic [WIDTH-1:0]       rs1_val_q, rs1_val_d;
  logic [WIDTH-1:0]       rs2_val_q, rs2_val_d;
  logic [WIDTH-1:0]       imm_q,     imm_d;
  logic [RF_ADD_SIZE-1:0] rd_q,      rd_d;
  logic                   rd_we_q,   rd_we_d;
  logic                   is_load_q, is_load_d;

  assign opcode = opcode_e'(i_instr[6:0]);
  assign rs1    = RF_ADD_SIZE'(i_instr[19:15]);
  assign rs2    = RF_ADD_SIZE'(i_instr[24:20]);
  assign rd     = RF_ADD_SIZE'(i_instr[11:7]);

  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;

  // Regfile writes land at the clock edge, so a same-cycle writeback is forwarded.
  function automatic logic [WIDTH-1:0] sel_operand(input logic [RF_ADD_SIZE-1:0] addr,
                                                   input logic [WIDTH-1:0]       rf_data);
    if (addr == '0)
      return '0;
    else if (i_wb_we && (i_wb_rd == addr))
      return i_wb_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    rd_we   = 1'b0;
    imm32   = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        use_rs1 = 1'b0;
        rd_we   = 1'b1;
        imm32   = {i_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        use_rs1 = 1'b0;
        rd_we   = 1'b1;
        imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        rd_we = 1'b1;
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OPC_STORE: begin
        use_rs2 = 1'b1;
        imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        use_rs2 = 1'b1;
        imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
      end
      OPC_OP: begin
        use_rs2 = 1'b1;
        rd_we   = 1'b1;
      end
      default: ;
    endcase
    if (rd == '0)
      rd_we = 1'b0;
  end

  assign is_load = (opcode == OPC_LOAD);

  // The bubble clears valid_q, so the re-decoded consumer never re-triggers.
  assign lu = valid_q & is_load_q & (rd_q != '0) & i_valid &
              ((use_rs1 & (rs1 == rd_q)) | (use_rs2 & (rs2 == rd_q)));

  assign o_stall = (lu | i_hold) & ~i_flush;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    if (i_flush) begin
      valid_d   = 1'b0;
      rd_we_d   = 1'b0;
      is_load_d = 1'b0;
    end else if (i_hold) begin
      valid_d = valid_q;
    end else if (lu) begin
      valid_d   = 1'b0;
      rd_we_d   = 1'b0;
      is_load_d = 1'b0;
    end else begin
      valid_d   = i_valid;
      pc_d      = i_pc;
      instr_d   = i_instr;
      rs1_val_d = sel_operand(rs1, i_rs1_data);
      rs2_val_d = sel_operand(rs2, i_rs2_data);
      imm_d     = WIDTH'($signed(imm32));
      rd_d      = rd;
      rd_we_d   = rd_we & i_valid;
      is_load_d = is_load & i_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_pc      = pc_q;
  assign o_instr   = instr_q;
  assign o_rs1_val = rs1_val_q;
  assign o_rs2_val = rs2_val_q;
  assign o_imm     = imm_q;
  assign o_rd      = rd_q;
  assign o_rd_we   = rd_we_q;
  assign o_is_load = is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: single-instruction decode vectors plus
// hand-written load-use, hold/flush and mid-stream reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [31:0] instr, pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, hold;
  logic        stall, o_valid_w;
  logic [31:0] o_pc_w, o_instr_w, o_rs1_w, o_rs2_w, o_imm_w;
  logic [4:0]  o_rd_w;
  logic        o_rd_we_w, o_is_load_w;

  int unsigned errors = 0;
  int unsigned checks = 0;

  id_ex_stage #(.WIDTH(32), .RF_ADD_SIZE(5)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_instr(instr), .i_pc(pc),
    .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
    .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_flush(flush), .i_hold(hold), .o_stall(stall),
    .o_valid(o_valid_w), .o_pc(o_pc_w), .o_instr(o_instr_w),
    .o_rs1_val(o_rs1_w), .o_rs2_val(o_rs2_w), .o_imm(o_imm_w),
    .o_rd(o_rd_w), .o_rd_we(o_rd_we_w), .o_is_load(o_is_load_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  exp_rs1a, exp_rs2a;
    logic        exp_valid;
    logic [31:0] exp_rs1, exp_rs2, exp_imm;
    logic [4:0]  exp_rd;
    logic        exp_rd_we, exp_is_load;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    valid = v;
    instr = ins;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"},   {31'b0, o_valid_w},   32'h0);
    check({tag, ".pc"},      o_pc_w,               32'h0);
    check({tag, ".instr"},   o_instr_w,            32'h0);
    check({tag, ".rs1"},     o_rs1_w,              32'h0);
    check({tag, ".rs2"},     o_rs2_w,              32'h0);
    check({tag, ".imm"},     o_imm_w,              32'h0);
    check({tag, ".rd"},      {27'b0, o_rd_w},      32'h0);
    check({tag, ".rd_we"},   {31'b0, o_rd_we_w},   32'h0);
    check({tag, ".is_load"}, {31'b0, o_is_load_w}, 32'h0);
    check({tag, ".stall"},   {31'b0, stall},       32'h0);
  endtask

  localparam logic [31:0] LW_X7   = 32'h00012383; // lw   x7,0(x2)
  localparam logic [31:0] ADD_X8  = 32'h00138433; // add  x8,x7,x1
  localparam logic [31:0] LUI_X7  = 32'h000383B7; // lui  x7,0x38 (rs1 field = 7)
  localparam logic [31:0] BEQ_X07 = 32'h00700063; // beq  x0,x7,0
  localparam logic [31:0] ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1

  initial begin
    //        name        v  instr          rs1d          rs2d          we   wbrd   wbdata        rs1a   rs2a   ev  ers1          ers2          eimm          erd    erdwe eld
    vecs[0] = '{"addi",   1, 32'hFFF00293, 32'h00000055, 32'h00000022, 0, 5'd0,  32'h0,        5'd0,  5'd31, 1, 32'h0,        32'h00000022, 32'hFFFFFFFF, 5'd5,  1, 0};
    vecs[1] = '{"add_byp",1, 32'h003180B3, 32'h00000011, 32'h00000011, 1, 5'd3,  32'h0000ABCD, 5'd3,  5'd3,  1, 32'h0000ABCD, 32'h0000ABCD, 32'h0,        5'd1,  1, 0};
    vecs[2] = '{"add_x0", 1, 32'h000000B3, 32'h00000077, 32'h00000077, 1, 5'd0,  32'h0000FFFF, 5'd0,  5'd0,  1, 32'h0,        32'h0,        32'h0,        5'd1,  1, 0};
    vecs[3] = '{"sw",     1, 32'hFE512E23, 32'h00000100, 32'h00000200, 1, 5'd5,  32'h00000999, 5'd2,  5'd5,  1, 32'h00000100, 32'h00000999, 32'hFFFFFFFC, 5'd28, 0, 0};
    vecs[4] = '{"beq",    1, 32'hFE208CE3, 32'h00000001, 32'h00000002, 0, 5'd1,  32'h00000123, 5'd1,  5'd2,  1, 32'h00000001, 32'h00000002, 32'hFFFFFFF8, 5'd25, 0, 0};
    vecs[5] = '{"lui",    1, 32'h123453B7, 32'h00000005, 32'h00000006, 0, 5'd0,  32'h0,        5'd8,  5'd3,  1, 32'h00000005, 32'h00000006, 32'h12345000, 5'd7,  1, 0};
    vecs[6] = '{"jal",    1, 32'h001000EF, 32'h00000009, 32'h0000000A, 0, 5'd0,  32'h0,        5'd0,  5'd1,  1, 32'h0,        32'h0000000A, 32'h00000800, 5'd1,  1, 0};
    vecs[7] = '{"auipc0", 1, 32'hFFFFF017, 32'h00000001, 32'h00000002, 1, 5'd31, 32'h0000DEAD, 5'd31, 5'd31, 1, 32'h0000DEAD, 32'h0000DEAD, 32'hFFFFF000, 5'd0,  0, 0};
    vecs[8] = '{"other",  1, 32'hFFF0000F, 32'h00000003, 32'h00000004, 0, 5'd0,  32'h0,        5'd0,  5'd31, 1, 32'h0,        32'h00000004, 32'h0,        5'd0,  0, 0};
    vecs[9] = '{"invalid",0, 32'hFFF00293, 32'h00000000, 32'h00000000, 0, 5'd0,  32'h0,        5'd0,  5'd31, 0, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd5,  0, 0};

    rstn = 1'b0; valid = 1'b0; instr = '0; pc = '0;
    rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; hold = 1'b0;
    tick(); tick();
    check_zero_outputs("reset");
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      valid = vecs[i].valid; instr = vecs[i].instr; pc = 32'h1000 + 32'(i) * 4;
      rs1_data = vecs[i].rs1_data; rs2_data = vecs[i].rs2_data;
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      #1;
      check({vecs[i].name, ".rs1_addr"}, {27'b0, rs1_addr}, {27'b0, vecs[i].exp_rs1a});
      check({vecs[i].name, ".rs2_addr"}, {27'b0, rs2_addr}, {27'b0, vecs[i].exp_rs2a});
      check({vecs[i].name, ".stall"},    {31'b0, stall},    32'h0);
      tick();
      check({vecs[i].name, ".valid"},   {31'b0, o_valid_w},   {31'b0, vecs[i].exp_valid});
      check({vecs[i].name, ".pc"},      o_pc_w,               32'h1000 + 32'(i) * 4);
      check({vecs[i].name, ".instr"},   o_instr_w,            vecs[i].instr);
      check({vecs[i].name, ".rs1_val"}, o_rs1_w,              vecs[i].exp_rs1);
      check({vecs[i].name, ".rs2_val"}, o_rs2_w,              vecs[i].exp_rs2);
      check({vecs[i].name, ".imm"},     o_imm_w,              vecs[i].exp_imm);
      check({vecs[i].name, ".rd"},      {27'b0, o_rd_w},      {27'b0, vecs[i].exp_rd});
      check({vecs[i].name, ".rd_we"},   {31'b0, o_rd_we_w},   {31'b0, vecs[i].exp_rd_we});
      check({vecs[i].name, ".is_load"}, {31'b0, o_is_load_w}, {31'b0, vecs[i].exp_is_load});
    end
    wb_we = 1'b0; rs1_data = '0; rs2_data = '0;

    // Load-use: LW x7 then ADD x8,x7,x1 -> exactly one bubble.
    drive(1'b1, LW_X7); tick();
    check("lu.lw_valid",   {31'b0, o_valid_w},   32'h1);
    check("lu.lw_is_load", {31'b0, o_is_load_w}, 32'h1);
    check("lu.lw_rd_we",   {31'b0, o_rd_we_w},   32'h1);
    drive(1'b1, ADD_X8); #1;
    check("lu.stall", {31'b0, stall}, 32'h1);
    tick();
    check("lu.bubble_valid", {31'b0, o_valid_w}, 32'h0);
    check("lu.bubble_rd_we", {31'b0, o_rd_we_w}, 32'h0);
    check("lu.bubble_stall", {31'b0, stall},     32'h0);
    tick();
    check("lu.add_valid", {31'b0, o_valid_w}, 32'h1);
    check("lu.add_instr", o_instr_w,          ADD_X8);
    check("lu.add_rd",    {27'b0, o_rd_w},    32'd8);
    check("lu.add_stall", {31'b0, stall},     32'h0);

    // LUI with rs1 field = x7 does not use rs1: no stall.
    drive(1'b1, LW_X7); tick();
    drive(1'b1, LUI_X7); #1;
    check("lui.stall", {31'b0, stall}, 32'h0);
    tick();
    check("lui.valid", {31'b0, o_valid_w}, 32'h1);
    check("lui.instr", o_instr_w,          LUI_X7);
    // BEQ x0,x7 uses rs2 = x7: stall.
    drive(1'b1, LW_X7); tick();
    drive(1'b1, BEQ_X07); #1;
    check("beq.stall", {31'b0, stall}, 32'h1);
    tick();
    check("beq.bubble", {31'b0, o_valid_w}, 32'h0);

    // Hold for 3 cycles with a live load-use: everything frozen, stall high.
    drive(1'b1, LW_X7); pc = 32'h2000; tick();
    drive(1'b1, ADD_X8); hold = 1'b1; pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold.stall", {31'b0, stall}, 32'h1);
      tick();
      check("hold.valid",   {31'b0, o_valid_w},   32'h1);
      check("hold.instr",   o_instr_w,            LW_X7);
      check("hold.pc",      o_pc_w,               32'h2000);
      check("hold.is_load", {31'b0, o_is_load_w}, 32'h1);
    end
    flush = 1'b1; #1;
    check("flush.stall", {31'b0, stall}, 32'h0);
    tick();
    check("flush.valid", {31'b0, o_valid_w}, 32'h0);
    check("flush.rd_we", {31'b0, o_rd_we_w}, 32'h0);
    flush = 1'b0; hold = 1'b0;

    // Mid-stream asynchronous reset.
    drive(1'b1, ADDI_M1); pc = 32'h3000; tick();
    check("mid.valid", {31'b0, o_valid_w}, 32'h1);
    valid = 1'b0; instr = '0; pc = '0;
    #2 rstn = 1'b0; #1;
    check_zero_outputs("midrst");
    tick();
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage and ID/EX pipeline register of the pipelined RV32I core. Sits between the IF/ID register and EX, directly around the register file.
- Drives the regfile read addresses from the fetched instruction and bypasses a same-cycle writeback, because regfile writes land only at the clock edge.
- Generates the immediate and detects load-use hazards, inserting one bubble per hazard.
- Registers everything EX consumes, with stall, hold and flush control.

Parameters:
- WIDTH, 32, datapath/PC width.
- RF_ADD_SIZE, 5, register address width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_instr  in  32  instruction word from IF/ID.
- i_pc  in  WIDTH  PC of i_instr.
- o_rs1_addr  out  RF_ADD_SIZE  regfile read address 0 = i_instr[19:15] (combinational).
- o_rs2_addr  out  RF_ADD_SIZE  regfile read address 1 = i_instr[24:20] (combinational).
- i_rs1_data  in  WIDTH  regfile read data 0.
- i_rs2_data  in  WIDTH  regfile read data 1.
- i_wb_we  in  1  writeback write enable (same signal that drives the regfile write).
- i_wb_rd  in  RF_ADD_SIZE  writeback destination.
- i_wb_data  in  WIDTH  writeback data.
- i_flush  in  1  EX redirect (taken branch/jump): kill the instruction in decode.
- i_hold  in  1  downstream stall: freeze the ID/EX register.
- o_stall  out  1  freeze PC and IF/ID (combinational).
- o_valid  out  1  ID/EX holds a valid instruction.
- o_pc  out  WIDTH  registered PC.
- o_instr  out  32  registered instruction.
- o_rs1_val  out  WIDTH  registered operand 1.
- o_rs2_val  out  WIDTH  registered operand 2.
- o_imm  out  WIDTH  registered sign-extended immediate.
- o_rd  out  RF_ADD_SIZE  registered destination.
- o_rd_we  out  1  registered register-write enable.
- o_is_load  out  1  registered: opcode 0000011.

Behaviour:
- Reset: all registered outputs 0 (o_valid=0, o_instr=0, o_rd_we=0, o_is_load=0).
- Decode (combinational, from i_instr):
  - use_rs1 = opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
  - use_rs2 = opcode in {BRANCH 1100011, STORE 0100011, OP 0110011}.
  - rd_we = opcode in {OP, OP-IMM 0010011, LOAD, LUI, AUIPC, JAL, JALR 1100111} and rd != 0.
- Immediate generation by opcode:
  - I-type (OP-IMM, LOAD, JALR): sign-extend instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}, sign-extended.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - Any other opcode: 0.
- Operand select, per source:
  - Address 0 → value 0, regardless of bypass.
  - Else if i_wb_we and i_wb_rd equals the source address → i_wb_data.
  - Else the regfile data.
- Load-use hazard: lu = o_valid & o_is_load & (o_rd != 0) & i_valid & ((use_rs1 & rs1 == o_rd) | (use_rs2 & rs2 == o_rd)).
- o_stall = (lu | i_hold) & ~i_flush.
- Register update at each posedge, in priority order:
  1. i_flush: o_valid <= 0 and o_rd_we <= 0; other fields don't-care.
  2. i_hold: all ID/EX registers keep their values.
  3. lu: bubble; o_valid <= 0, o_rd_we <= 0, o_is_load <= 0. IF/ID is frozen by o_stall, so the consumer re-decodes on the next cycle. That cycle lu is false because o_valid = 0.
  4. Otherwise: capture the decoded instruction. o_valid <= i_valid, o_rd_we <= rd_we & i_valid, o_is_load <= (opcode == LOAD) & i_valid.
- Bypass while i_hold is asserted: the held o_rs*_val is not refreshed. Writebacks that occur during a hold are picked up from the regfile once the hold ends, because the held instruction is already in EX.
- Load-use bubble: exactly one bubble per hazard. No back-to-back stall from the same load.
- Simultaneous i_flush with lu or i_hold: flush wins and o_stall = 0.
- Latency: 1 cycle from IF/ID to ID/EX outputs.

Test Plan:
- Reset mid-stream with o_valid=1 → next sample shows all outputs 0 and o_stall=0.
- ADDI x5,x0,-1 (0xFFF00293), valid → one cycle later o_imm=0xFFFFFFFF, o_rd=5, o_rd_we=1, o_rs1_val=0.
- Regfile returns 0x11 for x3 while i_wb_we=1, i_wb_rd=3, i_wb_data=0xABCD, instr ADD x1,x3,x3 → o_rs1_val=o_rs2_val=0xABCD. Same stimulus with i_wb_rd=0 writing 0xFFFF, decoding a read of x0 → operand 0.
- LW x7,0(x2) followed by ADD x8,x7,x1:
  - Cycle after the LW is captured: o_stall=1, then a bubble with o_valid=0.
  - Next cycle: the ADD is captured, o_valid=1, o_stall=0.
- LW x7 followed by LUI x7 (no source use) → no stall. BEQ x0,x7 → stall, because rs2 is used.
- i_hold=1 for 3 cycles with lu also true → outputs frozen and o_stall=1 throughout. Asserting i_flush with i_hold → o_valid=0 at the next edge and o_stall=0 that cycle.
